sram_sequencer: RTL and testbench
=================================

# sram_sequencer

Single-clock bus sequencer between the CPU's load/store port and the two-phase `staticram` array. Accepts one word request at a time over a valid/ready handshake, generates the `clk2` (address latch) and `clk1` (access) strobes, holds `RD`/`WR`/address/data stable around them, and returns read data with a response pulse. All memory-side outputs are registered, so the array sees glitch-free strobes.

## Interface
Parameters:
- `WordSize`, 16, data word width.
- `AddrWidth`, 16, word address width.

Ports:
- `clk`  in  1  system clock; every register updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  sequencer can accept a request this cycle.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  AddrWidth  word address.
- `req_wdata`  in  WordSize  write data.
- `resp_valid`  out  1  one-cycle pulse: access complete.
- `resp_rdata`  out  WordSize  read data, valid with `resp_valid` on reads and held until the next read completes.
- `mem_addr`  out  AddrWidth  to array `Addr`.
- `mem_din`  out  WordSize  to array `DataIn`.
- `mem_dout`  in  WordSize  from array `DataOut`.
- `mem_rd`, `mem_wr`  out  1 each  to array `RD`, `WR`.
- `mem_clk1`, `mem_clk2`  out  1 each  array strobes; each is high for exactly one `clk` cycle per access.

## Operation
- FSM: IDLE, SETUP, LATCH, EXEC, DONE. Encoding is one-hot.
- IDLE: `req_ready`=1. On `req_valid` && `req_ready`, register addr, data, and we into `mem_addr`, `mem_din`, and an internal `we_q`. Go to SETUP.
- SETUP: strobes low. Drive `mem_rd` = ~`we_q` and `mem_wr` = `we_q`, registered so they are valid entering LATCH. Go to LATCH.
- LATCH: `mem_clk2`=1. The array captures `mem_addr`. Go to EXEC.
- EXEC: `mem_clk2`=0, `mem_clk1`=1. The array reads into `DataOut` or writes `DataIn`. `mem_rd`/`mem_wr` stay held. Go to DONE.
- DONE: `mem_clk1`=0.
  - Read: capture `mem_dout` into `resp_rdata`.
  - Pulse `resp_valid` and clear `mem_rd`/`mem_wr`.
  - Go to IDLE.
- `mem_addr` and `mem_din` do not change outside IDLE→SETUP. Value after an access is the last request's value.
- `mem_rd` and `mem_wr` are never both 1. Both are 0 in IDLE.
- Requests arriving while `req_ready`=0 are not sampled. The CPU holds them.

## Timing
- Reset values:
  - Outputs 0: `req_ready`, `resp_valid`, `mem_rd`, `mem_wr`, `mem_clk1`, `mem_clk2`.
  - Buses 0: `mem_addr`, `mem_din`, `resp_rdata`.
  - State: IDLE.
  - `req_ready` rises on the first clock edge after `rst` deasserts.
- Latency: request accepted at edge N → `mem_clk2` high in cycle N+2 → `mem_clk1` high in N+3 → `resp_valid` high in N+4, `req_ready` high again in N+5. One access per 5 cycles, for reads and writes alike.
- Order: `mem_addr`/`RD`/`WR` are stable ≥1 cycle before the `mem_clk2` rise. `mem_rd`/`mem_wr` stay stable until after `mem_clk1` falls. The two strobes are never high in the same cycle.
- Simultaneous events: `req_valid` in DONE is ignored; it is accepted next cycle in IDLE.
- Reset mid-access:
  - Immediate return to IDLE. All strobes and `RD`/`WR` drop asynchronously. No `resp_valid`.
  - A write whose `mem_clk1` already rose is committed. Any earlier write is not.
- Address wrap: none. The full `AddrWidth` range is passed through unmodified. Address 2^AddrWidth−1 is legal.

## Structure
- Shared package `sram_pkg`: state enum `sram_state_t` plus default `WordSize`/`AddrWidth` constants shared with the array and CPU.
- No sub-module. A single FSM plus registers; the output decode is registered from the next-state.

## Test plan
- Reset in IDLE: `rst`=1 → all outputs 0. Release → `req_ready`=1 one cycle later.
- Write then read: write addr 0x0002 data 0x06CF → `mem_clk2` at N+2, `mem_clk1` at N+3 with `mem_wr`=1, `resp_valid` at N+4. Read 0x0002 → `resp_rdata`=0x06CF.
- Back-to-back: `req_valid` held high for reads of 0x000A then 0x0001 → accepts spaced exactly 5 cycles apart. Two `resp_valid` pulses, with data in request order.
- Protocol check each cycle:
  - `mem_clk1` & `mem_clk2` never both 1.
  - `mem_rd` & `mem_wr` never both 1.
  - `mem_addr` stable from SETUP through EXEC.
- Reset mid-access: assert `rst` during LATCH of a write to 0x0003 (data 0x1234) → strobes drop, no `resp_valid`. A later read of 0x0003 returns the pre-write value.
- Edge address: write/read 0xFFFF with data 0xFFFF → round-trip correct. `mem_addr`=0xFFFF, with no wrap to 0.

Source files
------------

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkg
//  Description : Shared constants and FSM state type for the sram_sequencer,
//                the staticram array and the CPU load/store port.
//                No ports (package).
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    // Default widths shared by the CPU port, the sequencer and the array
    localparam int c_WORD_SIZE  = 16;
    localparam int c_ADDR_WIDTH = 16;

    // One-hot state codes
    localparam logic [4:0] c_ST_IDLE  = 5'b00001;
    localparam logic [4:0] c_ST_SETUP = 5'b00010;
    localparam logic [4:0] c_ST_LATCH = 5'b00100;
    localparam logic [4:0] c_ST_EXEC  = 5'b01000;
    localparam logic [4:0] c_ST_DONE  = 5'b10000;

    typedef enum logic [4:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_SETUP = c_ST_SETUP,
        ST_LATCH = c_ST_LATCH,
        ST_EXEC  = c_ST_EXEC,
        ST_DONE  = c_ST_DONE
    } sram_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_sequencer_if
//  Description : CPU request/response handshake plus staticram array bus.
//                master : CPU + array side (drives requests and mem_dout)
//                slave  : sequencer side (drives ready/response and the
//                         array address, data, RD/WR and clk1/clk2 strobes)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_sequencer_if
    import sram_pkg::*;
#(
    parameter int WordSize  = c_WORD_SIZE,
    parameter int AddrWidth = c_ADDR_WIDTH
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [AddrWidth-1:0] req_addr;
    logic [WordSize-1:0]  req_wdata;
    logic                 resp_valid;
    logic [WordSize-1:0]  resp_rdata;
    logic [AddrWidth-1:0] mem_addr;
    logic [WordSize-1:0]  mem_din;
    logic [WordSize-1:0]  mem_dout;
    logic                 mem_rd;
    logic                 mem_wr;
    logic                 mem_clk1;
    logic                 mem_clk2;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata,
               mem_addr, mem_din, mem_rd, mem_wr, mem_clk1, mem_clk2
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata,
               mem_addr, mem_din, mem_rd, mem_wr, mem_clk1, mem_clk2
    );
endinterface
`default_nettype wire

// File: rtl/sram_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sram_sequencer
//  Description : Sequences one CPU word access at a time onto the two-phase
//                staticram array: SETUP -> LATCH (clk2) -> EXEC (clk1) ->
//                DONE (response). Every output is a flop decoded from the
//                next state, so the array sees glitch-free strobes.
//  Ports       : clk  - system clock
//                rst  - asynchronous active-high reset
//                bus  - sram_sequencer_if.slave (CPU handshake + array bus)
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_sequencer
    import sram_pkg::*;
#(
    parameter int WordSize  = c_WORD_SIZE,
    parameter int AddrWidth = c_ADDR_WIDTH
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sram_sequencer_if.slave   bus
);

    sram_state_t          state_q, state_d;
    logic                 ready_q;
    logic                 resp_valid_q;
    logic [WordSize-1:0]  rdata_q;
    logic [AddrWidth-1:0] addr_q;
    logic [WordSize-1:0]  din_q;
    logic                 we_q;
    logic                 rd_q, wr_q;
    logic                 clk1_q, clk2_q;

    logic                 w_accept;
    logic                 w_we_next;
    logic                 w_busy_next;

    // ready_q is only ever set while the FSM sits in IDLE
    assign w_accept    = ready_q & bus.req_valid;
    // RD/WR for SETUP must be decided on the accepting edge itself
    assign w_we_next   = w_accept ? bus.req_we : we_q;
    assign w_busy_next = (state_d != ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_accept) state_d = ST_SETUP;
            ST_SETUP: state_d = ST_LATCH;
            ST_LATCH: state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            we_q         <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            clk1_q       <= 1'b0;
            clk2_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= (state_d == ST_IDLE);
            clk2_q       <= (state_d == ST_LATCH);
            clk1_q       <= (state_d == ST_EXEC);
            resp_valid_q <= (state_d == ST_DONE);
            // RD/WR cover SETUP..DONE so they bracket both strobes
            rd_q         <= w_busy_next & ~w_we_next;
            wr_q         <= w_busy_next &  w_we_next;
            if (w_accept) begin
                addr_q <= bus.req_addr;
                din_q  <= bus.req_wdata;
                we_q   <= bus.req_we;
            end
            // DataOut is valid while clk1 is high; capture as EXEC ends
            if ((state_q == ST_EXEC) && !we_q) begin
                rdata_q <= bus.mem_dout;
            end
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_din    = din_q;
    assign bus.mem_rd     = rd_q;
    assign bus.mem_wr     = wr_q;
    assign bus.mem_clk1   = clk1_q;
    assign bus.mem_clk2   = clk2_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_sequencer
//  Description : Directed-vector bench for sram_sequencer with a behavioural
//                two-phase staticram model (addr latched on clk2 rise,
//                access on clk1 rise). Untouched words hold addr ^ 16'hA5A5.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_sequencer;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    sram_sequencer_if #(.WordSize(16), .AddrWidth(16)) bus ();

    sram_sequencer #(.WordSize(16), .AddrWidth(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- staticram model ----------------
    logic [15:0] mem [0:65535];
    logic [15:0] lat_addr;

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'hA5A5;
        lat_addr = 16'h0;
        bus.mem_dout = 16'h0;
    end

    always @(posedge bus.mem_clk2) lat_addr = bus.mem_addr;

    always @(posedge bus.mem_clk1) begin
        if (bus.mem_wr) mem[lat_addr] = bus.mem_din;
        if (bus.mem_rd) bus.mem_dout = mem[lat_addr];
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle protocol checks
    logic [15:0] prev_addr;
    logic        prev_busy;
    initial begin
        prev_addr = 16'h0;
        prev_busy = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            chk("proto_strobes_overlap", {31'd0, bus.mem_clk1 & bus.mem_clk2}, 32'd0);
            chk("proto_rd_wr_overlap",   {31'd0, bus.mem_rd & bus.mem_wr},     32'd0);
            if (prev_busy && (bus.mem_rd || bus.mem_wr))
                chk("proto_addr_stable", {16'd0, bus.mem_addr}, {16'd0, prev_addr});
            prev_busy = bus.mem_rd | bus.mem_wr;
            prev_addr = bus.mem_addr;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    // Call at a negedge with the FSM idle; returns at negedge of cycle N+5.
    task automatic run_access(input int id, input vec_t v);
        logic [4:0]  s_clk2, s_clk1, s_resp, s_rdy, s_rd, s_wr;
        logic [15:0] addr_k2, din_k2, rdata_k4;
        int          wait_n;
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        wait_n = 0;
        while (!bus.req_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        if (!bus.req_ready) begin
            chk($sformatf("v%0d_accept_timeout", id), 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        addr_k2 = 16'h0; din_k2 = 16'h0; rdata_k4 = 16'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) bus.req_valid = 1'b0;
            s_clk2[k] = bus.mem_clk2;
            s_clk1[k] = bus.mem_clk1;
            s_resp[k] = bus.resp_valid;
            s_rdy[k]  = bus.req_ready;
            s_rd[k]   = bus.mem_rd;
            s_wr[k]   = bus.mem_wr;
            if (k == 1) begin addr_k2 = bus.mem_addr; din_k2 = bus.mem_din; end
            if (k == 3) rdata_k4 = bus.resp_rdata;
        end
        chk($sformatf("v%0d_clk2_timing", id), {27'd0, s_clk2}, {27'd0, 5'b00010});
        chk($sformatf("v%0d_clk1_timing", id), {27'd0, s_clk1}, {27'd0, 5'b00100});
        chk($sformatf("v%0d_resp_timing", id), {27'd0, s_resp}, {27'd0, 5'b01000});
        chk($sformatf("v%0d_ready_timing", id), {27'd0, s_rdy}, {27'd0, 5'b10000});
        chk($sformatf("v%0d_wr_window", id), {27'd0, s_wr}, {27'd0, v.we ? 5'b01111 : 5'b00000});
        chk($sformatf("v%0d_rd_window", id), {27'd0, s_rd}, {27'd0, v.we ? 5'b00000 : 5'b01111});
        chk($sformatf("v%0d_mem_addr", id), {16'd0, addr_k2}, {16'd0, v.addr});
        if (v.we) chk($sformatf("v%0d_mem_din", id), {16'd0, din_k2}, {16'd0, v.wdata});
        else      chk($sformatf("v%0d_rdata", id), {16'd0, rdata_k4}, {16'd0, v.exp_rdata});
    endtask

    vec_t vecs [7];

    logic [15:0] b2b_data [4];
    int          acc_k [4];
    int          acc_cnt, resp_cnt;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{1'b1, 16'h0002, 16'h06CF, 16'h0000};
        vecs[1] = '{1'b0, 16'h0002, 16'h0000, 16'h06CF};
        vecs[2] = '{1'b0, 16'h0005, 16'h0000, 16'hA5A0};
        vecs[3] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[4] = '{1'b0, 16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[5] = '{1'b1, 16'h1234, 16'hBEEF, 16'h0000};
        vecs[6] = '{1'b0, 16'h1234, 16'h0000, 16'hBEEF};

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 16'h0;

        // ---- reset state ----
        @(negedge clk);
        @(negedge clk);
        chk("reset_ctrl", {26'd0, bus.req_ready, bus.resp_valid, bus.mem_rd,
                           bus.mem_wr, bus.mem_clk1, bus.mem_clk2}, 32'd0);
        chk("reset_buses", {bus.mem_addr, bus.mem_din}, 32'd0);
        chk("reset_rdata", {16'd0, bus.resp_rdata}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_before_edge", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_release", {31'd0, bus.req_ready}, 32'd1);

        // ---- table-driven accesses ----
        for (int i = 0; i < 7; i++) run_access(i, vecs[i]);

        // ---- back-to-back reads with req_valid held high ----
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h000A;
        acc_cnt  = 0;
        resp_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.req_valid && bus.req_ready && acc_cnt < 4) begin
                acc_k[acc_cnt] = k;
                acc_cnt++;
            end
            @(negedge clk);
            if (acc_cnt == 1) bus.req_addr = 16'h0001;
            if (acc_cnt == 2) bus.req_valid = 1'b0;
            if (bus.resp_valid && resp_cnt < 4) begin
                b2b_data[resp_cnt] = bus.resp_rdata;
                resp_cnt++;
            end
        end
        chk("b2b_accept_count", acc_cnt, 32'd2);
        if (acc_cnt == 2) chk("b2b_accept_spacing", acc_k[1] - acc_k[0], 32'd5);
        chk("b2b_resp_count", resp_cnt, 32'd2);
        if (resp_cnt >= 1) chk("b2b_rdata0", {16'd0, b2b_data[0]}, 32'h0000A5AF);
        if (resp_cnt >= 2) chk("b2b_rdata1", {16'd0, b2b_data[1]}, 32'h0000A5A4);

        // ---- reset during LATCH of a write ----
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0003;
        bus.req_wdata = 16'h1234;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_in_latch", {31'd0, bus.mem_clk2}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_async_drop", {27'd0, bus.mem_clk2, bus.mem_clk1, bus.mem_wr,
                                  bus.mem_rd, bus.req_ready}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("midrst_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_back", {31'd0, bus.req_ready}, 32'd1);
        chk("midrst_no_resp_after", {31'd0, bus.resp_valid}, 32'd0);
        run_access(7, '{1'b0, 16'h0003, 16'h0000, 16'hA5A6});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
